// File: rtl/read_pointer_empty_generate_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer conversions,
// used by both the read-side and write-side pointer stages.
package read_pointer_empty_generate_pkg;

  localparam int ADDRESS_SIZE_DEFAULT  = 4;
  localparam int POINTER_WIDTH_DEFAULT = ADDRESS_SIZE_DEFAULT + 1;

  // Conversions work on a wide word; callers zero-extend and size-cast back,
  // so one function body serves every pointer width.
  typedef logic [31:0] ptr_word_t;

  function automatic ptr_word_t bin_to_gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray_to_bin(input ptr_word_t g);
    ptr_word_t b;
    b     = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/read_pointer_empty_generate_if.sv
// Read-side FIFO pointer bundle: pop request and write Gray pointer in, address/flags out.
// read_underflow exists only when READ_UNDERFLOW_FLAG_EN is defined.
interface read_pointer_empty_generate_if #(
  parameter int ADDRESS_SIZE = read_pointer_empty_generate_pkg::ADDRESS_SIZE_DEFAULT
);
  logic                    read_inc;
  logic [ADDRESS_SIZE:0]   write_gray_pointer;
  logic [ADDRESS_SIZE-1:0] read_address;
  logic [ADDRESS_SIZE:0]   read_gray_pointer;
  logic                    read_empty;
  logic                    read_almost_empty;
  logic [ADDRESS_SIZE:0]   read_level;
`ifdef READ_UNDERFLOW_FLAG_EN
  logic                    read_underflow;
`endif

  modport master (
    output read_inc, write_gray_pointer,
`ifdef READ_UNDERFLOW_FLAG_EN
    input  read_underflow,
`endif
    input  read_address, read_gray_pointer, read_empty, read_almost_empty, read_level
  );

  modport slave (
    input  read_inc, write_gray_pointer,
`ifdef READ_UNDERFLOW_FLAG_EN
    output read_underflow,
`endif
    output read_address, read_gray_pointer, read_empty, read_almost_empty, read_level
  );
endinterface

// File: rtl/read_pointer_empty_generate_gray_pointer_synchronizer.sv
// WIDTH x STAGES flop chain for crossing a Gray pointer into another clock domain.
// Only the last stage is visible; reset clears every stage asynchronously.
module gray_pointer_synchronizer #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/read_pointer_empty_generate.sv
// Read-domain pointer/flag stage of the async FIFO: pop counter, Gray pointer, empty/almost-empty/level.
// Optional sticky read_underflow output under READ_UNDERFLOW_FLAG_EN.
module read_pointer_empty_generate
  import read_pointer_empty_generate_pkg::*;
#(
  parameter int          ADDRESS_SIZE       = ADDRESS_SIZE_DEFAULT,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 2,
  parameter int          SYNC_STAGES        = 2
) (
  input  logic                          read_clk,
  input  logic                          read_reset_n,
  read_pointer_empty_generate_if.slave  rif
);

  localparam int PTR_W = ADDRESS_SIZE + 1;

  logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_gray_sync, wr_bin_sync;
  logic             empty_q, empty_d;
  logic             aempty_q, aempty_d;
  logic             pop;

  gray_pointer_synchronizer #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk   (read_clk),
    .rst_n (read_reset_n),
    .d_i   (rif.write_gray_pointer),
    .q_o   (wr_gray_sync)
  );

  // Flags are computed against the post-pop pointer so empty lands on the final pop edge.
  always_comb begin
    pop         = rif.read_inc & ~empty_q;
    rd_bin_d    = rd_bin_q + PTR_W'(pop);
    rd_gray_d   = PTR_W'(bin_to_gray(ptr_word_t'(rd_bin_d)));
    wr_bin_sync = PTR_W'(gray_to_bin(ptr_word_t'(wr_gray_sync)));
    level_d     = wr_bin_sync - rd_bin_d;
    empty_d     = (rd_gray_d == wr_gray_sync);
    aempty_d    = (32'(level_d) <= 32'(ALMOST_EMPTY_LEVEL));
  end

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
    end
  end

  assign rif.read_address      = rd_bin_q[ADDRESS_SIZE-1:0];
  assign rif.read_gray_pointer = rd_gray_q;
  assign rif.read_empty        = empty_q;
  assign rif.read_almost_empty = aempty_q;
  assign rif.read_level        = level_q;

`ifdef READ_UNDERFLOW_FLAG_EN
  logic underflow_q;

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) underflow_q <= 1'b0;
    else               underflow_q <= underflow_q | (rif.read_inc & empty_q);
  end

  assign rif.read_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_read_pointer_empty_generate.sv
// Directed bench for the read-side pointer/empty stage: reset, sync latency, drain, wrap, almost-empty, async reset.
module tb_read_pointer_empty_generate;

  logic read_clk = 1'b0;
  logic read_reset_n;
  int   errors = 0;
  int   checks = 0;

  always #5 read_clk = ~read_clk;

  read_pointer_empty_generate_if #(.ADDRESS_SIZE(4)) rif ();

  read_pointer_empty_generate #(
    .ADDRESS_SIZE       (4),
    .ALMOST_EMPTY_LEVEL (2),
    .SYNC_STAGES        (2)
  ) dut (
    .read_clk     (read_clk),
    .read_reset_n (read_reset_n),
    .rif          (rif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  initial begin
    read_reset_n           = 1'b0;
    rif.read_inc           = 1'b0;
    rif.write_gray_pointer = 5'b00000;
    #12;
    check("rst_empty",  32'(rif.read_empty), 1);
    check("rst_aempty", 32'(rif.read_almost_empty), 1);
    check("rst_level",  32'(rif.read_level), 0);
    check("rst_gray",   32'(rif.read_gray_pointer), 0);
    check("rst_addr",   32'(rif.read_address), 0);
    tick();
    read_reset_n = 1'b1;

    // Pops while empty are ignored
    rif.read_inc = 1'b1;
    repeat (3) tick();
    rif.read_inc = 1'b0;
    check("ign_gray",  32'(rif.read_gray_pointer), 0);
    check("ign_addr",  32'(rif.read_address), 0);
    check("ign_empty", 32'(rif.read_empty), 1);
    check("ign_level", 32'(rif.read_level), 0);
`ifdef READ_UNDERFLOW_FLAG_EN
    check("uf_set", 32'(rif.read_underflow), 1);
`endif

    // Write pointer -> binary 2, visible three edges later
    rif.write_gray_pointer = 5'b00011;
    tick();
    check("lat1_empty", 32'(rif.read_empty), 1);
    tick();
    check("lat2_empty", 32'(rif.read_empty), 1);
    tick();
    check("lat3_empty",  32'(rif.read_empty), 0);
    check("lat3_level",  32'(rif.read_level), 2);
    check("lat3_aempty", 32'(rif.read_almost_empty), 1);

    // Write pointer -> binary 16, drain all 16 words
    rif.write_gray_pointer = 5'b11000;
    repeat (3) tick();
    check("full_level",  32'(rif.read_level), 16);
    check("full_aempty", 32'(rif.read_almost_empty), 0);
    for (int i = 0; i < 16; i++) begin
      rif.read_inc = 1'b1;
      check($sformatf("drain_addr%0d", i), 32'(rif.read_address), 32'(i));
      tick();
      check($sformatf("drain_level%0d", i), 32'(rif.read_level), 32'(15 - i));
      check($sformatf("drain_empty%0d", i), 32'(rif.read_empty), (i == 15) ? 1 : 0);
      check($sformatf("drain_aempty%0d", i), 32'(rif.read_almost_empty), (15 - i <= 2) ? 1 : 0);
    end
    tick();
    rif.read_inc = 1'b0;
    check("drain_gray", 32'(rif.read_gray_pointer), 32'h18);
    check("drain_addr", 32'(rif.read_address), 0);
`ifdef READ_UNDERFLOW_FLAG_EN
    check("uf_sticky", 32'(rif.read_underflow), 1);
`endif

    // Write pointer -> binary 30, drain 14
    rif.write_gray_pointer = 5'b10001;
    repeat (3) tick();
    check("w30_level", 32'(rif.read_level), 14);
    for (int i = 0; i < 14; i++) begin
      rif.read_inc = 1'b1;
      tick();
      check($sformatf("w30_level%0d", i), 32'(rif.read_level), 32'(13 - i));
      check($sformatf("w30_empty%0d", i), 32'(rif.read_empty), (i == 13) ? 1 : 0);
    end
    rif.read_inc = 1'b0;
    check("w30_gray", 32'(rif.read_gray_pointer), 32'h11);

    // Write pointer wraps to binary 3; read pointer crosses 31 -> 0
    rif.write_gray_pointer = 5'b00010;
    repeat (3) tick();
    check("wrap_level",  32'(rif.read_level), 5);
    check("wrap_empty",  32'(rif.read_empty), 0);
    rif.read_inc = 1'b1;
    tick();
    check("wrap31_gray",  32'(rif.read_gray_pointer), 32'h10);
    check("wrap31_level", 32'(rif.read_level), 4);
    check("wrap31_addr",  32'(rif.read_address), 15);
    tick();
    check("wrap0_gray",   32'(rif.read_gray_pointer), 0);
    check("wrap0_level",  32'(rif.read_level), 3);
    check("wrap0_empty",  32'(rif.read_empty), 0);
    check("wrap0_aempty", 32'(rif.read_almost_empty), 0);
    check("wrap0_addr",   32'(rif.read_address), 0);
    tick();
    check("ae_gray",   32'(rif.read_gray_pointer), 32'h01);
    check("ae_level",  32'(rif.read_level), 2);
    check("ae_aempty", 32'(rif.read_almost_empty), 1);
    check("ae_empty",  32'(rif.read_empty), 0);
    tick();
    check("ae1_level", 32'(rif.read_level), 1);
    tick();
    rif.read_inc = 1'b0;
    check("wrapend_level", 32'(rif.read_level), 0);
    check("wrapend_empty", 32'(rif.read_empty), 1);
    check("wrapend_gray",  32'(rif.read_gray_pointer), 32'h02);

    // Write pointer -> binary 5, then asynchronous reset mid-operation
    rif.write_gray_pointer = 5'b00111;
    repeat (3) tick();
    check("pre_rst_level", 32'(rif.read_level), 2);
    #3;
    read_reset_n = 1'b0;
    #1;
    check("arst_level",  32'(rif.read_level), 0);
    check("arst_empty",  32'(rif.read_empty), 1);
    check("arst_aempty", 32'(rif.read_almost_empty), 1);
    check("arst_gray",   32'(rif.read_gray_pointer), 0);
    check("arst_addr",   32'(rif.read_address), 0);
`ifdef READ_UNDERFLOW_FLAG_EN
    check("uf_clr", 32'(rif.read_underflow), 0);
`endif
    tick();
    read_reset_n = 1'b1;
    repeat (2) tick();
    check("post_rst_lat", 32'(rif.read_empty), 1);
    tick();
    check("post_rst_level", 32'(rif.read_level), 5);
    check("post_rst_empty", 32'(rif.read_empty), 0);
`ifdef READ_UNDERFLOW_FLAG_EN
    check("uf_stay_clr", 32'(rif.read_underflow), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
